uart_tx_core: RTL and testbench

- Serial transmit engine driven by the UART register block; sits directly downstream of the cfg, ctrl and tx_data registers.
- Consumes `tx_data`, the frame-format fields and the `start_tx` level.
- Serialises one asynchronous frame on `tx`: start bit, 5-8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Returns `tx_done` for the status register and a one-cycle `start_tx_re_cfg` pulse that clears the ctrl register.

---
 rtl/uart_tx_core.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: asynchronous-frame serial transmitter.
// Sends start bit, 5..8 data bits LSB first, optional even/odd parity and
// 1 or 2 stop bits. The frame format is captured when a frame is accepted,
// so register writes during a frame only affect the next one.
// Optional feature macro: UART_TX_BREAK_EN adds the send_break input, which
// holds the line low while the transmitter is idle.
// Every output is driven straight from a flop; tx has no combinational path
// from any input.

module uart_tx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       start_tx,
`ifdef UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       tx,
    output logic       tx_done,
    output logic       start_tx_re_cfg,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Last value of the baud counter within one bit period.
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Registered state.
    state_t             r_state;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;     // data bit index, or stop bit index in STOP
    logic [7:0]         r_data;        // shadowed byte, bits >= D already cleared
    logic [2:0]         r_last_bit;    // D-1
    logic               r_two_stop;
    logic               r_par_en;
    logic               r_par_type;
    logic               r_tx;
    logic               r_tx_done;
    logic               r_tx_busy;
    logic               r_re_cfg;

    // Next-state values.
    state_t             w_state_next;
    logic [CNT_W-1:0]   w_baud_next;
    logic [2:0]         w_bit_next;
    logic [7:0]         w_data_next;
    logic [2:0]         w_last_next;
    logic               w_two_stop_next;
    logic               w_par_en_next;
    logic               w_par_type_next;
    logic               w_tx_next;
    logic               w_done_next;
    logic               w_busy_next;
    logic               w_re_cfg_next;

    // Helpers.
    logic               w_bit_end;
    logic [2:0]         w_bit_inc;
    logic               w_parity;
    logic [2:0]         w_load_last;
    logic [7:0]         w_load_mask;

    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign w_bit_inc   = r_bit_idx + 3'd1;

    // D-1 for the incoming frame: 00 -> 4 (5 bits) ... 11 -> 7 (8 bits).
    assign w_load_last = 3'd4 + {1'b0, data_bit_num};

    // Keep only the low D bits of tx_data when it is shadowed, so unused
    // high bits can neither be transmitted nor disturb the parity.
    for (genvar gi = 0; gi < 8; gi++) begin : g_load_mask
        assign w_load_mask[gi] = (3'(gi) <= w_load_last);
    end

    // Unused bits are already zero, so the XOR of the whole byte is the
    // XOR of the D transmitted bits. Odd parity inverts it.
    assign w_parity = (^r_data) ^ r_par_type;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
        w_bit_next      = r_bit_idx;
        w_data_next     = r_data;
        w_last_next     = r_last_bit;
        w_two_stop_next = r_two_stop;
        w_par_en_next   = r_par_en;
        w_par_type_next = r_par_type;
        w_tx_next       = r_tx;
        w_done_next     = r_tx_done;
        w_busy_next     = r_tx_busy;
        w_re_cfg_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_bit_next  = 3'd0;
                w_done_next = 1'b1;
                if (start_tx) begin
                    // Accept a frame. The format is frozen here for the whole frame.
                    w_state_next    = S_START;
                    w_data_next     = tx_data & w_load_mask;
                    w_last_next     = w_load_last;
                    w_two_stop_next = stop_bit_num;
                    w_par_en_next   = parity_en;
                    w_par_type_next = parity_type;
                    w_re_cfg_next   = 1'b1;
                    w_done_next     = 1'b0;
                    w_busy_next     = 1'b1;
                    w_tx_next       = 1'b0;
                end else begin
`ifdef UART_TX_BREAK_EN
                    // Break condition: line held low while requested.
                    w_tx_next   = ~send_break;
                    w_busy_next = send_break;
`else
                    w_tx_next   = 1'b1;
                    w_busy_next = 1'b0;
`endif
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_data[0];
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == r_last_bit) begin
                        w_bit_next = 3'd0;
                        if (r_par_en) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = w_parity;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_next = w_bit_inc;
                        w_tx_next  = r_data[w_bit_inc];
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_bit_next   = 3'd0;
                    w_tx_next    = 1'b1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    if (r_two_stop && (r_bit_idx == 3'd0)) begin
                        // Second stop bit; line stays high.
                        w_bit_next = 3'd1;
                        w_tx_next  = 1'b1;
                    end else begin
                        // Frame complete: status flags change on this edge.
                        w_state_next = S_IDLE;
                        w_bit_next   = 3'd0;
                        w_tx_next    = 1'b1;
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                    end
                end
            end

            default: begin
                // Unreachable encodings recover to a quiet idle line.
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_bit_next   = 3'd0;
                w_tx_next    = 1'b1;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_data     <= 8'h00;
            r_last_bit <= 3'd7;
            r_two_stop <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_re_cfg   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_data     <= w_data_next;
            r_last_bit <= w_last_next;
            r_two_stop <= w_two_stop_next;
            r_par_en   <= w_par_en_next;
            r_par_type <= w_par_type_next;
            r_tx       <= w_tx_next;
            r_tx_done  <= w_done_next;
            r_tx_busy  <= w_busy_next;
            r_re_cfg   <= w_re_cfg_next;
        end
    end

    assign tx              = r_tx;
    assign tx_done         = r_tx_done;
    assign tx_busy         = r_tx_busy;
    assign start_tx_re_cfg = r_re_cfg;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: self-checking bench for uart_tx_core (CLKS_PER_BIT=16).
// The expected line waveform of each frame is built from the frame format
// (start, D data bits, parity from the count of ones, stop bits) and compared
// bit period by bit period. Build with UART_TX_BREAK_EN to cover break.

module tb_uart_tx_core;

    localparam int CPB = 16;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       start_tx;
`ifdef UART_TX_BREAK_EN
    logic       send_break;
`endif
    logic       tx;
    logic       tx_done;
    logic       start_tx_re_cfg;
    logic       tx_busy;

    int total = 0;
    int bad   = 0;

    uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tx_data         (tx_data),
        .data_bit_num    (data_bit_num),
        .stop_bit_num    (stop_bit_num),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .start_tx        (start_tx),
`ifdef UART_TX_BREAK_EN
        .send_break      (send_break),
`endif
        .tx              (tx),
        .tx_done         (tx_done),
        .start_tx_re_cfg (start_tx_re_cfg),
        .tx_busy         (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Sends one frame starting at the next negedge and checks it cycle by
    // cycle. hold keeps start_tx high; at cycle mutate_at every input is
    // scrambled (and break raised if mid_break) to prove shadowing.
    task automatic run_frame(input logic [7:0] data, input logic [1:0] dbn,
                             input logic sb, input logic pe, input logic pt,
                             input bit hold, input int mutate_at,
                             input bit mid_break, input string tag);
        logic exp_bits[$];
        int   d, ones, n_cyc, flag_err;
        bit   lvl_ok;
        logic bad_lvl;
        d    = 5 + int'(dbn);
        ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < d; i++) begin
            exp_bits.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (pe) exp_bits.push_back(pt ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
        exp_bits.push_back(1'b1);
        if (sb) exp_bits.push_back(1'b1);
        n_cyc    = exp_bits.size() * CPB;
        flag_err = 0;
        lvl_ok   = 1'b1;
        bad_lvl  = 1'b1;

        @(negedge clk);
        tx_data      = data;
        data_bit_num = dbn;
        stop_bit_num = sb;
        parity_en    = pe;
        parity_type  = pt;
        start_tx     = 1'b1;

        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++;
                if (start_tx_re_cfg !== 1'b1) begin
                    bad++;
                    $display("FAIL %s re_cfg_pulse: got=%b want=1", tag, start_tx_re_cfg);
                end
                if (!hold) start_tx = 1'b0;
            end
            if (k == 1) begin
                total++;
                if (start_tx_re_cfg !== 1'b0) begin
                    bad++;
                    $display("FAIL %s re_cfg_single: got=%b want=0", tag, start_tx_re_cfg);
                end
            end
            if ((k % CPB) == 0) lvl_ok = 1'b1;
            if (tx !== exp_bits[k / CPB]) begin
                lvl_ok  = 1'b0;
                bad_lvl = tx;
            end
            if (tx_done !== 1'b0 || tx_busy !== 1'b1) flag_err++;
            if (k == mutate_at) begin
                tx_data      = 8'h00;
                data_bit_num = ~dbn;
                stop_bit_num = ~sb;
                parity_en    = ~pe;
                parity_type  = ~pt;
`ifdef UART_TX_BREAK_EN
                if (mid_break) send_break = 1'b1;
`endif
            end
            if ((k % CPB) == CPB - 1) begin
                total++;
                if (!lvl_ok) begin
                    bad++;
                    $display("FAIL %s bit%0d: got=%b want=%b", tag, k / CPB, bad_lvl, exp_bits[k / CPB]);
                end
            end
        end

        total++;
        if (flag_err != 0) begin
            bad++;
            $display("FAIL %s done_busy_in_frame: got=%0d bad cycles want=0", tag, flag_err);
        end

        // First idle cycle after the stop bit(s).
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || start_tx_re_cfg !== 1'b0) begin
            bad++;
            $display("FAIL %s frame_end: got tx=%b done=%b busy=%b re=%b want 1 1 0 0",
                     tag, tx, tx_done, tx_busy, start_tx_re_cfg);
        end
`ifdef UART_TX_BREAK_EN
        send_break = 1'b0;
`endif
        $display("frame %s data=%h D=%0d P=%0b S=%0d cycles=%0d hold=%0b brk=%0b",
                 tag, data, d, pe, sb ? 2 : 1, n_cyc, hold, mid_break);
    endtask

    task automatic test_reset();
        int err;
        reset_n      = 1'b0;
        tx_data      = 8'h00;
        data_bit_num = 2'b00;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        start_tx     = 1'b0;
`ifdef UART_TX_BREAK_EN
        send_break   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || start_tx_re_cfg !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got tx=%b done=%b busy=%b re=%b want 1 1 0 0",
                     tx, tx_done, tx_busy, start_tx_re_cfg);
        end
        reset_n = 1'b1;
        err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || start_tx_re_cfg !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL idle_stable: got=%0d bad cycles want=0", err);
        end
        $display("reset released, idle checked");
    endtask

    task automatic test_directed();
        run_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, "8N1");
        run_frame(8'hFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, "7E2");
        run_frame(8'h03, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0, "5O1");
    endtask

    task automatic test_back_to_back();
        // Inputs scrambled at cycle 40 (DATA); start_tx stays high.
        run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 40, 1'b0, "robust_8N1");
        // Next frame must begin right after the single idle cycle.
        @(negedge clk);
        total++;
        if (tx !== 1'b0 || start_tx_re_cfg !== 1'b1 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start: got tx=%b re=%b done=%b want 0 1 0",
                     tx, start_tx_re_cfg, tx_done);
        end
        start_tx = 1'b0;
        // Second frame carries 0x00, so the line is low through bit period 4.
        repeat (69) @(negedge clk);
        total++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_bit4: got tx=%b busy=%b want 0 1", tx, tx_busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0 || start_tx_re_cfg !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_abort: got tx=%b done=%b busy=%b re=%b want 1 1 0 0",
                     tx, tx_done, tx_busy, start_tx_re_cfg);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("b2b frame aborted by reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 90)),
                      1'b0, "rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        int good;
        good = 0;
        @(negedge clk);
        send_break = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tx === 1'b0 && tx_busy === 1'b1 && tx_done === 1'b1) good++;
            if (i == 40) send_break = 1'b0;
        end
        total++;
        if (good != 40) begin
            bad++;
            $display("FAIL break_low_cycles: got=%0d want=40", good);
        end
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL break_release: got tx=%b busy=%b want 1 0", tx, tx_busy);
        end
        $display("break held 40 cycles");
        run_frame(8'h5A, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 50, 1'b1, "break_midframe");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
